// File: rtl/attn_v_spikes_serializer.sv
// Unpacks one packed attn@v spike word into P_CNT_MAX slices, low slice first, valid/ready on both sides.
// Optional one-word prefetch (gapless throughput) is enabled by defining SERIALIZER_PREFETCH_EN.
module attn_v_spikes_serializer #(
  parameter int TIME_STEPS        = 4,
  parameter int PATCH_EMBED_WIDTH = 32
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic [PATCH_EMBED_WIDTH*2-1:0] i_word_data,
  input  logic                           i_word_valid,
  output logic                           o_word_ready,
  output logic [TIME_STEPS*2-1:0]        o_slice_data,
  output logic                           o_slice_valid,
  output logic                           o_slice_last,
  input  logic                           i_slice_ready
);

  localparam int SW        = TIME_STEPS * 2;
  localparam int WW        = PATCH_EMBED_WIDTH * 2;
  localparam int P_CNT_MAX = PATCH_EMBED_WIDTH / TIME_STEPS;
  localparam int CW        = (P_CNT_MAX > 1) ? $clog2(P_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P_CNT_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [WW-1:0]   word_r, word_s;
  logic [SW-1:0]   slice_s;
  logic            word_hs_s;
  logic            slice_hs_s;
  logic            last_s;

`ifdef SERIALIZER_PREFETCH_EN
  logic [WW-1:0]   pf_r, pf_s;
  logic            pf_full_r, pf_full_s;

  assign o_word_ready = !pf_full_r;
`else
  assign o_word_ready = (state_r == ST_IDLE);
`endif

  // Outputs depend on registers only; no path from the inputs.
  assign o_slice_valid = (state_r == ST_SEND);
  assign last_s        = (cnt_r == CNT_LAST);
  assign o_slice_last  = o_slice_valid && last_s;
  assign o_slice_data  = o_slice_valid ? slice_s : {SW{1'b0}};

  assign word_hs_s  = i_word_valid && o_word_ready;
  assign slice_hs_s = o_slice_valid && i_slice_ready;

  // Select the slice addressed by the counter.
  always_comb begin
    slice_s = word_r[32'(cnt_r) * SW +: SW];
  end

  // Next-state logic: slice counter, held word and optional prefetch slot.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    word_s  = word_r;
`ifdef SERIALIZER_PREFETCH_EN
    pf_s      = pf_r;
    pf_full_s = pf_full_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (word_hs_s) begin
          word_s  = i_word_data;
          cnt_s   = {CW{1'b0}};
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
`ifdef SERIALIZER_PREFETCH_EN
        // A word arriving on the last-slice handshake bypasses the slot and loads directly.
        if (word_hs_s && !(slice_hs_s && last_s)) begin
          pf_s      = i_word_data;
          pf_full_s = 1'b1;
        end else begin
          pf_s = pf_r;
        end
`endif
        if (slice_hs_s) begin
          if (last_s) begin
            cnt_s = {CW{1'b0}};
`ifdef SERIALIZER_PREFETCH_EN
            if (pf_full_r) begin
              word_s    = pf_r;
              pf_full_s = 1'b0;
              state_s   = ST_SEND;
            end else if (word_hs_s) begin
              word_s  = i_word_data;
              state_s = ST_SEND;
            end else begin
              state_s = ST_IDLE;
            end
`else
            state_s = ST_IDLE;
`endif
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State registers; reset drops any partially sent word.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      word_r  <= {WW{1'b0}};
`ifdef SERIALIZER_PREFETCH_EN
      pf_r      <= {WW{1'b0}};
      pf_full_r <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      word_r  <= word_s;
`ifdef SERIALIZER_PREFETCH_EN
      pf_r      <= pf_s;
      pf_full_r <= pf_full_s;
`endif
    end
  end

endmodule

// File: tb/tb_attn_v_spikes_serializer.sv
// Self-checking bench for attn_v_spikes_serializer: queue-based slice model, packer loopback
// model, directed literal cases and a randomized 100-word run with a random sink.
module tb_attn_v_spikes_serializer;

  localparam int NS = 8;

  logic        s_clk = 1'b0;
  logic        s_rst;
  logic [63:0] i_word_data;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [7:0]  o_slice_data;
  logic        o_slice_valid;
  logic        o_slice_last;
  logic        i_slice_ready;

  int tests = 0;
  int fails = 0;

  logic [7:0]  exp_q[$];
  logic [63:0] word_q[$];
  logic [63:0] pack_acc;
  int          pack_cnt = 0;
  logic        rand_done;

  attn_v_spikes_serializer #(.TIME_STEPS(4), .PATCH_EMBED_WIDTH(32)) dut (
    .s_clk        (s_clk),
    .s_rst        (s_rst),
    .i_word_data  (i_word_data),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_slice_data (o_slice_data),
    .o_slice_valid(o_slice_valid),
    .o_slice_last (o_slice_last),
    .i_slice_ready(i_slice_ready)
  );

  always #5 s_clk = ~s_clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: queue of outstanding slices plus a packer that rebuilds whole words.
  always @(negedge s_clk) begin
    if (s_rst) begin
      check("rst_valid", o_slice_valid, 1'b0);
      check("rst_ready", o_word_ready, 1'b1);
      check("rst_data",  o_slice_data, 8'h00);
      check("rst_last",  o_slice_last, 1'b0);
      exp_q.delete();
      word_q.delete();
      pack_cnt = 0;
    end else begin
      check("valid", o_slice_valid, exp_q.size() > 0);
`ifdef SERIALIZER_PREFETCH_EN
      check("ready", o_word_ready, exp_q.size() <= NS);
`else
      check("ready", o_word_ready, exp_q.size() == 0);
`endif
      if (exp_q.size() > 0) begin
        check("data", o_slice_data, exp_q[0]);
        check("last", o_slice_last, (exp_q.size() % NS) == 1);
      end else begin
        check("idle_data", o_slice_data, 8'h00);
        check("idle_last", o_slice_last, 1'b0);
      end
      if (o_slice_valid && i_slice_ready && exp_q.size() > 0) begin
        pack_acc[pack_cnt*8 +: 8] = o_slice_data;
        pack_cnt++;
        void'(exp_q.pop_front());
        if (pack_cnt == NS) begin
          pack_cnt = 0;
          check("pack_last", o_slice_last, 1'b1);
          if (word_q.size() > 0) begin
            check("loopback", pack_acc, word_q.pop_front());
          end else begin
            check("loopback_extra", pack_acc, 64'hx);
          end
        end
      end
      if (i_word_valid && o_word_ready) begin
        word_q.push_back(i_word_data);
        for (int k = 0; k < NS; k++) exp_q.push_back(i_word_data[k*8 +: 8]);
      end
    end
  end

  task automatic send_word(input logic [63:0] w);
    int   n;
    logic hs;
    i_word_data  = w;
    i_word_valid = 1'b1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 300) begin
      @(negedge s_clk);
      hs = o_word_ready;
      @(posedge s_clk);
      #1;
      n++;
    end
    i_word_valid = 1'b0;
    check("word_accept", hs, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (o_slice_valid && n < 1000) begin
      @(posedge s_clk);
      #1;
      n++;
    end
    check("drain", o_slice_valid, 1'b0);
  endtask

  initial begin
    int first, last, total;
    s_rst         = 1'b1;
    i_word_valid  = 1'b0;
    i_word_data   = 64'h0;
    i_slice_ready = 1'b0;
    rand_done     = 1'b0;
    repeat (2) @(posedge s_clk);
    #1;
    check("reset_ready", o_word_ready, 1'b1);
    check("reset_valid", o_slice_valid, 1'b0);
    check("reset_data",  o_slice_data, 8'h00);
    s_rst = 1'b0;
    @(posedge s_clk);
    #1;

    // Single word, sink always ready: slices 01..08 on consecutive cycles.
    i_slice_ready = 1'b1;
    send_word(64'h0807_0605_0403_0201);
    for (int k = 0; k < NS; k++) begin
      @(negedge s_clk);
      check("t1_valid", o_slice_valid, 1'b1);
      check("t1_data",  o_slice_data, 8'(k + 1));
      check("t1_last",  o_slice_last, k == NS - 1);
    end
    drain();

    // Back-to-back words: count span of valid cycles.
    first = -1; last = -1; total = 0;
    fork
      begin
        send_word(64'h1817_1615_1413_1211);
        send_word(64'h2827_2625_2423_2221);
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(negedge s_clk);
          if (o_slice_valid) begin
            if (first < 0) first = c;
            last = c;
            total++;
          end
        end
      end
    join
    check("t2_total", total, 16);
`ifdef SERIALIZER_PREFETCH_EN
    check("t2_span", last - first + 1, 16);
`else
    check("t2_span", last - first + 1, 17);
`endif
    drain();

    // Hold the sink at slice 3 for 5 cycles.
    send_word(64'h8877_6655_4433_2211);
    repeat (3) @(posedge s_clk);
    #1;
    i_slice_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge s_clk);
      check("t4_hold", o_slice_data, 8'h44);
    end
    @(posedge s_clk);
    #1;
    i_slice_ready = 1'b1;
    @(negedge s_clk);
    check("t4_release", o_slice_data, 8'h44);
    @(negedge s_clk);
    check("t4_next", o_slice_data, 8'h55);
    drain();

    // Reset after slice 4 of a word; next word restarts at slice 0.
    send_word(64'hF8F7_F6F5_F4F3_F2F1);
    repeat (5) @(posedge s_clk);
    #1;
    s_rst = 1'b1;
    #1;
    check("t5_valid", o_slice_valid, 1'b0);
    check("t5_ready", o_word_ready, 1'b1);
    check("t5_data",  o_slice_data, 8'h00);
    @(posedge s_clk);
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    send_word(64'hA8A7_A6A5_A4A3_A2A1);
    @(negedge s_clk);
    check("t5_restart", o_slice_data, 8'hA1);
    drain();

    // Random words and random sink readiness.
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge s_clk);
            #1;
          end
          send_word({$urandom(), $urandom()});
        end
        i_slice_ready = 1'b1;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge s_clk);
          #1;
          if (!rand_done) i_slice_ready = $urandom_range(0, 1) == 1;
        end
      end
    join
    i_slice_ready = 1'b1;
    drain();
    @(negedge s_clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("words_empty", word_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
